// File: rtl/instr_stage_sequencer.sv
// instr_stage_sequencer: multicycle FETCH/DECODE/EXEC/MEM/WB sequencer for the
// 16-bit RISC core. Steps each instruction through the stages its opcode class
// needs, stalls on imem/dmem ready and issues the PC write strobe in the last
// cycle of the instruction.
//
// Optional build macro SEQ_PERF_CNT_EN adds cycle_count / instr_count outputs.
//
// Handshake: imem_ready is only looked at in FETCH and dmem_ready only in MEM;
// a stage waiting on its ready holds its state and its stage enable, and no
// pc_we is issued in a stalled cycle. The current state is visible on 'stage'.
module instr_stage_sequencer #(
  parameter int OPW   = 4,
  parameter int CNT_W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           run,
  input  logic [OPW-1:0] opcode,
  input  logic           imem_ready,
  input  logic           dmem_ready,
  output logic [2:0]     stage,
  output logic           ir_we,
  output logic           cu_enable,
  output logic           alu_en,
  output logic           mem_en,
  output logic           wb_en,
  output logic           pc_we,
  output logic           instr_done
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;

  // Elaboration-time sanity check of the parameters.
  if (OPW < 4 || CNT_W < 1) begin : g_bad_param
    $error("instr_stage_sequencer: OPW must be >= 4 and CNT_W >= 1");
  end

  state_t     r_state;
  state_t     w_next;
  logic       r_instr_done;
  logic [3:0] w_op;
  logic       w_is_load;
  logic       w_is_store;
  logic       w_is_branch;
  logic       w_is_jump;
  state_t     w_boundary;
  logic       w_ir_we;
  logic       w_cu_enable;
  logic       w_alu_en;
  logic       w_mem_en;
  logic       w_wb_en;
  logic       w_pc_we;

  // Opcode class decode; ALU ops are everything not listed here (0000-0100).
  assign w_op        = opcode[3:0];
  assign w_is_load   = (w_op == 4'b0101) || (w_op == 4'b0110);
  assign w_is_store  = (w_op == 4'b0111) || (w_op == 4'b1111);
  assign w_is_branch = (w_op[3:2] == 2'b10);
  assign w_is_jump   = (w_op == 4'b1100) || (w_op == 4'b1101) || (w_op == 4'b1110);

  // run is only sampled at the instruction boundary.
  assign w_boundary  = run ? S_FETCH : S_IDLE;

  // State register; reset abandons any instruction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state, Moore stage enables and the Mealy pc_we strobe.
  always_comb begin
    w_next      = r_state;
    w_ir_we     = 1'b0;
    w_cu_enable = 1'b0;
    w_alu_en    = 1'b0;
    w_mem_en    = 1'b0;
    w_wb_en     = 1'b0;
    w_pc_we     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (run) w_next = S_FETCH;
      end
      S_FETCH: begin
        w_ir_we = imem_ready;
        if (imem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        w_cu_enable = 1'b1;
        if (w_is_jump) begin
          // CALL's link write happens in the control unit under cu_enable.
          w_pc_we = 1'b1;
          w_next  = w_boundary;
        end else begin
          w_next  = S_EXEC;
        end
      end
      S_EXEC: begin
        w_alu_en = 1'b1;
        if (w_is_branch) begin
          w_pc_we = 1'b1;
          w_next  = w_boundary;
        end else if (w_is_load || w_is_store) begin
          w_next  = S_MEM;
        end else begin
          w_next  = S_WB;
        end
      end
      S_MEM: begin
        w_mem_en = 1'b1;
        if (dmem_ready) begin
          if (w_is_store) begin
            w_pc_we = 1'b1;
            w_next  = w_boundary;
          end else begin
            w_next  = S_WB;
          end
        end
      end
      S_WB: begin
        w_wb_en = 1'b1;
        w_pc_we = 1'b1;
        w_next  = w_boundary;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // instr_done is pc_we delayed by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr_done <= 1'b0;
    end else begin
      r_instr_done <= w_pc_we;
    end
  end

  assign stage      = r_state;
  assign ir_we      = w_ir_we;
  assign cu_enable  = w_cu_enable;
  assign alu_en     = w_alu_en;
  assign mem_en     = w_mem_en;
  assign wb_en      = w_wb_en;
  assign pc_we      = w_pc_we;
  assign instr_done = r_instr_done;

`ifdef SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] r_cycle_count;
  logic [CNT_W-1:0] r_instr_count;

  // Free-running busy-cycle and retired-instruction counters, wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_count <= '0;
      r_instr_count <= '0;
    end else begin
      if (r_state != S_IDLE) r_cycle_count <= r_cycle_count + 1'b1;
      if (w_pc_we)           r_instr_count <= r_instr_count + 1'b1;
    end
  end

  assign cycle_count = r_cycle_count;
  assign instr_count = r_instr_count;
`endif

endmodule

// File: doc/instr_stage_sequencer.md
Name: instr_stage_sequencer

Overview:
Multicycle stage sequencer for the 16-bit RISC core. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB according to its 4-bit opcode class, and raises cu_enable and the per-stage enables that gate the control unit's outputs into the datapath. It stalls on instruction/data memory ready, issues the PC write strobe, and supports run/halt.

Parameters:
OPW, 4, opcode width
CNT_W, 32, width of performance counters (used only with the optional feature)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
run  in  1  level; 1 = sequence instructions, 0 = halt at next instruction boundary
opcode  in  OPW  opcode field of IR; valid from DECODE until the instruction ends
imem_ready  in  1  instruction memory data valid this cycle
dmem_ready  in  1  data memory access complete this cycle
stage  out  3  current state: 0 IDLE, 1 FETCH, 2 DECODE, 3 EXEC, 4 MEM, 5 WB
ir_we  out  1  IR load strobe
cu_enable  out  1  control unit enable
alu_en  out  1  EXEC stage enable
mem_en  out  1  MEM stage enable (MemR/MemW qualifier)
wb_en  out  1  register write-back enable (RegW qualifier)
pc_we  out  1  PC update strobe, last cycle of instruction
instr_done  out  1  registered 1-cycle pulse, the cycle after pc_we

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs 0, including instr_done. Reset mid-instruction abandons the instruction; no pc_we is issued.
- IDLE: if run=1, go to FETCH next cycle; else stay.
- FETCH: ir_we=imem_ready. Go to DECODE when imem_ready=1; stay otherwise.
- DECODE: cu_enable=1 for exactly one cycle. Next state depends on opcode class:
  - ALU ops 0000-0100 (AND, ADD, SUB, ANDI, ADDI): EXEC, then WB.
  - Loads 0101-0110 (LW, LBu/LBs): EXEC, then MEM, then WB.
  - Stores 0111 (SW) and 1111 (Sv): EXEC, then MEM; ends in MEM.
  - Branches 1000-1011: EXEC; ends in EXEC.
  - Jumps 1100-1110 (JMP, CALL, RET): end in DECODE. CALL's link write is done by the control unit under cu_enable, not WB.
- EXEC: alu_en=1, one cycle.
- MEM: mem_en=1. Stay until dmem_ready=1.
- WB: wb_en=1, one cycle.
- pc_we (Mealy) = 1 in the final cycle of each class:
  - DECODE for jumps.
  - EXEC for branches.
  - MEM with dmem_ready=1 for stores.
  - WB for ALU ops and loads.
  - Never asserted in a stalled cycle.
- After the final cycle: go to FETCH if run=1, else IDLE. run is sampled only at the boundary; deasserting run mid-instruction completes the instruction.
- Cycle counts with zero wait: ALU 4, load 5, store 4, branch 3, jump 2.
- Every wait cycle adds exactly one cycle. Ready inputs are ignored outside their own state.
- cu_enable, alu_en, mem_en, wb_en and ir_we are mutually exclusive.

Optional Feature:
Macro SEQ_PERF_CNT_EN.
- Defined: adds outputs cycle_count[CNT_W] and instr_count[CNT_W].
  - cycle_count increments every cycle state != IDLE.
  - instr_count increments on pc_we.
  - Both wrap modulo 2^CNT_W and clear on rst_n=0.
- Undefined: neither the ports nor the registers exist; all other behaviour is identical.

Test Plan:
- Reset, then run=1, imem_ready=dmem_ready=1, opcode 0001 (ADD): stage 0→1→2→3→5. pc_we high only in the WB cycle; instr_done high the next cycle; wb_en exactly 1 cycle.
- opcode 0101 (LW) with dmem_ready low for 3 MEM cycles: stage stays 4 for 4 cycles, mem_en high for all 4, pc_we only on the 4th; total 8 cycles.
- opcode 1100 (JMP): pc_we in the DECODE cycle, 2 cycles total, alu_en never high. opcode 1010 (BEQ): pc_we in EXEC, 3 cycles.
- opcode 0111 (SW) then 1111 (Sv) back-to-back: both end in MEM with pc_we. wb_en stays 0 throughout; FETCH follows immediately.
- run dropped during EXEC of an ADDI: instruction completes through WB, then stage=0 and holds. rst_n pulsed low during MEM: all outputs 0 asynchronously, no pc_we.
- With SEQ_PERF_CNT_EN, 10 ADD instructions, no stalls: instr_count=10, cycle_count=40. With CNT_W=4, 17 jumps: instr_count wraps to 1.
